// File: rtl/sha3_miner_pkg.sv
// rtl/sha3_miner_pkg.sv - shared constants and FSM encoding for the sha3 miner CSR block
package sha3_miner_pkg;

    localparam logic [4:0] ADDR_HEADER0   = 5'd0;
    localparam logic [4:0] ADDR_DIFF0     = 5'd8;
    localparam logic [4:0] ADDR_NONCE_LO  = 5'd16;
    localparam logic [4:0] ADDR_NONCE_HI  = 5'd17;
    localparam logic [4:0] ADDR_CTRL      = 5'd18;
    localparam logic [4:0] ADDR_STATUS    = 5'd19;
    localparam logic [4:0] ADDR_ACK       = 5'd20;
    localparam logic [4:0] ADDR_SOL_LO    = 5'd21;
    localparam logic [4:0] ADDR_SOL_HI    = 5'd22;
    localparam logic [4:0] ADDR_RUNCNT_LO = 5'd23;
    localparam logic [4:0] ADDR_RUNCNT_HI = 5'd24;

    localparam int CTRL_GO       = 0;
    localparam int CTRL_TEST     = 1;
    localparam int CTRL_HALT     = 2;
    localparam int CTRL_AUTO     = 3;
    localparam int CTRL_IRQ_EN   = 4;
    localparam int CTRL_PADF_LSB = 16;
    localparam int CTRL_PADL_LSB = 24;

    localparam int MC_RUN      = 0;
    localparam int MC_TEST     = 1;
    localparam int MC_HALT     = 2;
    localparam int MC_PADL_LSB = 3;
    localparam int MC_PADF_LSB = 11;
    localparam int MC_WIDTH    = 19;

    localparam int STAGES = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FOUND = 2'd2,
        ST_GAP   = 2'd3
    } csr_state_t;

endpackage

// File: rtl/sha3_csr_snap64.sv
// rtl/sha3_csr_snap64.sv - 64-bit read snapshot: reading the low word latches the high word
module sha3_csr_snap64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] value,
    input  logic        rd_lo,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    logic [31:0] hi_shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_shadow <= '0;
        end else if (rd_lo) begin
            hi_shadow <= value[63:32];
        end
    end

    assign lo = value[31:0];
    assign hi = hi_shadow;

endmodule

// File: rtl/sha3_miner_csr.sv
// rtl/sha3_miner_csr.sv - Avalon-MM control/status front end sequencing one sha3_256 miner
// Optional run-cycle counter enabled by defining SHA3_CSR_RUNCNT_EN.
module sha3_miner_csr
    import sha3_miner_pkg::*;
#(
    parameter int RESTART_GAP = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [4:0]     avs_address,
    input  logic           avs_write,
    input  logic [31:0]    avs_writedata,
    input  logic           avs_read,
    output logic [31:0]    avs_readdata,
    output logic           irq_out,
    output logic [255:0]   miner_header,
    output logic [255:0]   miner_difficulty,
    output logic [63:0]    miner_start_nonce,
    output logic [18:0]    miner_control,
    input  logic [63:0]    miner_solution,
    input  logic [6:0]     miner_status,
    input  logic           miner_irq
);

    csr_state_t   state, state_next;
    logic [255:0] header_r, diff_r;
    logic [63:0]  nonce_r, sol_r;
    logic         test_r, halt_r, auto_r, irq_en_r;
    logic [7:0]   padf_r, padl_r;
    logic         pending, irq_q;
    logic [7:0]   gap_cnt;
    logic [31:0]  rd_mux;
    logic [31:0]  sol_lo, sol_hi, runcnt_lo, runcnt_hi;

    logic ctrl_wr, go_stop, ack_wr, irq_rise, capture, restart, cfg_wr, run;

    assign ctrl_wr  = avs_write && (avs_address == ADDR_CTRL);
    assign go_stop  = ctrl_wr && !avs_writedata[CTRL_GO];
    assign ack_wr   = avs_write && (avs_address == ADDR_ACK) && avs_writedata[0];
    assign irq_rise = miner_irq && !irq_q;
    // go=0 overrides everything, so it also suppresses a same-cycle capture
    assign capture  = (state == ST_RUN) && irq_rise && !go_stop;
    assign restart  = (state == ST_FOUND) && (state_next == ST_GAP);
    assign cfg_wr   = avs_write && (state == ST_IDLE);
    assign run      = (state == ST_RUN) || (state == ST_FOUND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (ctrl_wr && avs_writedata[CTRL_GO]) state_next = ST_RUN;
            ST_RUN:   if (irq_rise) state_next = ST_FOUND;
            ST_FOUND: if (ack_wr && auto_r && !halt_r) state_next = ST_GAP;
            ST_GAP:   if (gap_cnt == 8'd0) state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase
        if (go_stop) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            header_r <= '0;
            diff_r   <= '0;
            nonce_r  <= '0;
            sol_r    <= '0;
            test_r   <= 1'b0;
            halt_r   <= 1'b0;
            auto_r   <= 1'b0;
            irq_en_r <= 1'b0;
            padf_r   <= '0;
            padl_r   <= '0;
            pending  <= 1'b0;
            irq_q    <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            irq_q <= miner_irq;

            if (cfg_wr && (avs_address[4:3] == 2'b00)) begin
                header_r[{avs_address[2:0], 5'b0} +: 32] <= avs_writedata;
            end
            if (cfg_wr && (avs_address[4:3] == 2'b01)) begin
                diff_r[{avs_address[2:0], 5'b0} +: 32] <= avs_writedata;
            end

            if (restart) begin
                nonce_r <= sol_r + 64'd1;
            end else if (cfg_wr && (avs_address == ADDR_NONCE_LO)) begin
                nonce_r[31:0] <= avs_writedata;
            end else if (cfg_wr && (avs_address == ADDR_NONCE_HI)) begin
                nonce_r[63:32] <= avs_writedata;
            end

            if (ctrl_wr) begin
                test_r   <= avs_writedata[CTRL_TEST];
                halt_r   <= avs_writedata[CTRL_HALT];
                auto_r   <= avs_writedata[CTRL_AUTO];
                irq_en_r <= avs_writedata[CTRL_IRQ_EN];
                padf_r   <= avs_writedata[CTRL_PADF_LSB +: 8];
                padl_r   <= avs_writedata[CTRL_PADL_LSB +: 8];
            end

            if (capture) begin
                sol_r   <= miner_solution;
                pending <= 1'b1;
            end else if (ack_wr) begin
                pending <= 1'b0;
            end

            if (restart) begin
                gap_cnt <= 8'(RESTART_GAP - 1);
            end else if ((state == ST_GAP) && (gap_cnt != 8'd0)) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    sha3_csr_snap64 u_sol_snap (
        .clk   (clk),
        .rst_n (rst_n),
        .value (sol_r),
        .rd_lo (avs_read && (avs_address == ADDR_SOL_LO)),
        .lo    (sol_lo),
        .hi    (sol_hi)
    );

`ifdef SHA3_CSR_RUNCNT_EN
    logic [63:0] runcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runcnt <= '0;
        end else if ((state == ST_IDLE) && (state_next == ST_RUN)) begin
            runcnt <= '0;
        end else if ((state == ST_RUN) && !miner_irq) begin
            runcnt <= runcnt + 64'd1;
        end
    end

    sha3_csr_snap64 u_runcnt_snap (
        .clk   (clk),
        .rst_n (rst_n),
        .value (runcnt),
        .rd_lo (avs_read && (avs_address == ADDR_RUNCNT_LO)),
        .lo    (runcnt_lo),
        .hi    (runcnt_hi)
    );
`else
    assign runcnt_lo = '0;
    assign runcnt_hi = '0;
`endif

    always_comb begin
        rd_mux = '0;
        if (avs_address[4:3] == 2'b00) begin
            rd_mux = header_r[{avs_address[2:0], 5'b0} +: 32];
        end else if (avs_address[4:3] == 2'b01) begin
            rd_mux = diff_r[{avs_address[2:0], 5'b0} +: 32];
        end else begin
            case (avs_address)
                ADDR_NONCE_LO:  rd_mux = nonce_r[31:0];
                ADDR_NONCE_HI:  rd_mux = nonce_r[63:32];
                ADDR_CTRL:      rd_mux = {padl_r, padf_r, 11'd0, irq_en_r, auto_r,
                                          halt_r, test_r, (state != ST_IDLE)};
                ADDR_STATUS:    rd_mux = {15'd0, pending, 6'd0, state, 1'b0, miner_status};
                ADDR_SOL_LO:    rd_mux = sol_lo;
                ADDR_SOL_HI:    rd_mux = sol_hi;
                ADDR_RUNCNT_LO: rd_mux = runcnt_lo;
                ADDR_RUNCNT_HI: rd_mux = runcnt_hi;
                default:        rd_mux = '0;
            endcase
        end
    end

    // Registered read returns pre-write contents on a same-cycle read+write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avs_readdata <= '0;
        end else begin
            avs_readdata <= avs_read ? rd_mux : 32'd0;
        end
    end

    assign irq_out           = pending && irq_en_r;
    assign miner_header      = header_r;
    assign miner_difficulty  = diff_r;
    assign miner_start_nonce = nonce_r;

    always_comb begin
        miner_control                        = '0;
        miner_control[MC_RUN]                = run;
        miner_control[MC_TEST]               = test_r;
        miner_control[MC_HALT]               = halt_r;
        miner_control[MC_PADL_LSB +: 8]      = padl_r;
        miner_control[MC_PADF_LSB +: 8]      = padf_r;
    end

endmodule

// File: tb/tb_sha3_miner_csr.sv
// tb/tb_sha3_miner_csr.sv - directed self-checking bench for sha3_miner_csr
module tb_sha3_miner_csr;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   avs_address;
    logic         avs_write;
    logic [31:0]  avs_writedata;
    logic         avs_read;
    logic [31:0]  avs_readdata;
    logic         irq_out;
    logic [255:0] miner_header;
    logic [255:0] miner_difficulty;
    logic [63:0]  miner_start_nonce;
    logic [18:0]  miner_control;
    logic [63:0]  miner_solution;
    logic [6:0]   miner_status;
    logic         miner_irq;

    int checks = 0;
    int failures = 0;
    logic [31:0] rdv;
    logic [31:0] runcnt_exp;

    always #5 clk = ~clk;

    sha3_miner_csr #(.RESTART_GAP(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .irq_out           (irq_out),
        .miner_header      (miner_header),
        .miner_difficulty  (miner_difficulty),
        .miner_start_nonce (miner_start_nonce),
        .miner_control     (miner_control),
        .miner_solution    (miner_solution),
        .miner_status      (miner_status),
        .miner_irq         (miner_irq)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d        = avs_readdata;
        avs_read = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        avs_address    = '0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        avs_read       = 1'b0;
        miner_solution = '0;
        miner_status   = 7'h05;
        miner_irq      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("reset_irq_out", irq_out, 0);
        chk("reset_control", miner_control, 0);
        chk("reset_nonce", miner_start_nonce, 0);
        chk("reset_header", miner_header, 0);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), rdv);
            chk($sformatf("reset_word%0d", i), rdv, (i == 19) ? 32'h5 : 32'h0);
        end

        wr(5'd0, 32'h10);
        wr(5'd7, 32'hA5A5_0000);
        wr(5'd8, 32'h10);
        wr(5'd16, 32'h10);
        chk("header_out", miner_header, {32'hA5A5_0000, 192'd0, 32'h10});
        chk("diff_out", miner_difficulty, 256'h10);
        wr(5'd18, 32'h13);
        chk("run_control", miner_control, 19'h3);
        chk("run_nonce", miner_start_nonce, 64'h10);
        rd(5'd19, rdv);
        chk("run_status", rdv, 32'h105);

        wr(5'd16, 32'h99);
        rd(5'd16, rdv);
        chk("nonce_wr_in_run", rdv, 32'h10);
        chk("nonce_out_in_run", miner_start_nonce, 64'h10);

        miner_solution = 64'h1234;
        miner_irq      = 1'b1;
        @(negedge clk);
        chk("found_irq_out", irq_out, 1);
        chk("found_run_held", miner_control[0], 1);
        rd(5'd19, rdv);
        chk("found_status", rdv, 32'h1_0205);
        rd(5'd21, rdv);
        chk("sol_lo", rdv, 32'h1234);
        rd(5'd22, rdv);
        chk("sol_hi", rdv, 32'h0);

        wr(5'd18, 32'h1B);
        wr(5'd20, 32'h1);
        miner_irq = 1'b0;
        chk("ack_irq_out", irq_out, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("gap_run_low%0d", i), miner_control[0], 0);
            chk($sformatf("gap_nonce%0d", i), miner_start_nonce, 64'h1235);
            @(negedge clk);
        end
        chk("gap_rerun", miner_control[0], 1);

        miner_solution = 64'hFFFF_FFFF_FFFF_FFFF;
        miner_irq      = 1'b1;
        wr(5'd20, 32'h1);
        chk("ack_vs_capture_irq", irq_out, 1);
        rd(5'd19, rdv);
        chk("ack_vs_capture_status", rdv, 32'h1_0205);
        rd(5'd22, rdv);
        chk("sol_hi_stale_shadow", rdv, 32'h0);
        rd(5'd21, rdv);
        chk("sol_lo_all_ones", rdv, 32'hFFFF_FFFF);
        rd(5'd22, rdv);
        chk("sol_hi_latched", rdv, 32'hFFFF_FFFF);

        wr(5'd20, 32'h1);
        miner_irq = 1'b0;
        chk("wrap_nonce", miner_start_nonce, 64'h0);
        chk("wrap_gap_run", miner_control[0], 0);
        wr(5'd18, 32'h1A);
        rd(5'd19, rdv);
        chk("stop_from_gap_status", rdv, 32'h5);
        repeat (6) @(negedge clk);
        chk("stop_stays_idle", miner_control, 19'h2);

        wr(5'd16, 32'h50);
        wr(5'd18, 32'h1F);
        chk("halt_run_control", miner_control, 19'h7);
        chk("idle_nonce_wr", miner_start_nonce, 64'h50);
        repeat (100) @(negedge clk);
`ifdef SHA3_CSR_RUNCNT_EN
        runcnt_exp = 32'd100;
`else
        runcnt_exp = 32'd0;
`endif
        rd(5'd23, rdv);
        chk("runcnt_lo", rdv, runcnt_exp);
        rd(5'd24, rdv);
        chk("runcnt_hi", rdv, 32'h0);

        miner_status   = 7'h2A;
        miner_solution = 64'h77;
        miner_irq      = 1'b1;
        @(negedge clk);
        wr(5'd20, 32'h1);
        rd(5'd19, rdv);
        chk("halt_ack_stays_found", rdv, 32'h22A);
        chk("halt_run_held", miner_control[0], 1);
        chk("halt_ack_irq_out", irq_out, 0);

        miner_solution = 64'h99;
        miner_irq      = 1'b0;
        @(negedge clk);
        miner_irq = 1'b1;
        @(negedge clk);
        rd(5'd21, rdv);
        chk("found_rise_ignored", rdv, 32'h77);
        chk("found_rise_no_irq", irq_out, 0);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_control", miner_control, 0);
        chk("async_rst_nonce", miner_start_nonce, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        miner_irq = 1'b0;
        rd(5'd19, rdv);
        chk("post_rst_status", rdv, 32'h2A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
